// File: rtl/fx2_multi_ep_pkg.sv
// Shared encodings for the FX2 slave-FIFO master: FSM states, FIFO
// addresses and flag bit positions.
package fx2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OUT_TURN,
      ST_OUT_RD,
      ST_IN_SEL,
      ST_IN_WR,
      ST_IN_PKTEND
   } state_t;

   localparam logic [1:0] ADR_EP2 = 2'b00;
   localparam logic [1:0] ADR_EP4 = 2'b01;
   localparam logic [1:0] ADR_EP6 = 2'b10;
   localparam logic [1:0] ADR_EP8 = 2'b11;

   localparam int FLAG_EP2 = 0;   // EP2 has data
   localparam int FLAG_IN0 = 1;   // first IN channel not-full flag

   // IN channel k sits at FIFOADR k+1 (EP4, EP6, EP8)
   function automatic logic [1:0] chan_adr(input logic [1:0] ch);
      return ADR_EP4 + ch;
   endfunction

endpackage

// File: rtl/fx2_multi_ep_if.sv
// Core-side streams of the FX2 master: command words out of EP2 and the
// device->host sample/reply channels.
interface fx2_multi_ep_if #(
   parameter int FD_WIDTH = 8,
   parameter int N_IN     = 3
);
   logic [FD_WIDTH-1:0]            cmd;
   logic                           cmd_wr;
   logic                           cmd_full;
   logic [N_IN-1:0][FD_WIDTH-1:0]  in_data;
   logic [N_IN-1:0]                in_rdy;
   logic [N_IN-1:0]                in_ack;
   logic [N_IN-1:0]                in_end;

   modport master (output cmd, cmd_wr, in_ack, input cmd_full, in_data, in_rdy, in_end);
   modport slave  (input cmd, cmd_wr, in_ack, output cmd_full, in_data, in_rdy, in_end);
endinterface

// File: rtl/fx2_multi_ep_rr_arbiter.sv
// Round-robin arbiter for the IN channels. The pointer names the first
// channel to consider; it moves past the winner whenever a grant is taken.
module fx2_rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         take,
   output logic         any,
   output logic [1:0]   gidx
);
   logic [1:0] ptr;

   // first requester at or after the pointer, wrapping round
   always_comb begin
      logic [1:0] j;
      any  = 1'b0;
      gidx = ptr;
      j    = ptr;
      for (int i = 0; i < N; i++) begin
         if (!any && req[j]) begin
            any  = 1'b1;
            gidx = j;
         end
         j = (j == 2'(N - 1)) ? 2'd0 : j + 2'd1;
      end
   end

   // rotate past the channel that was just granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 2'd0;
      else if (take)
         ptr <= (gidx == 2'(N - 1)) ? 2'd0 : gidx + 2'd1;
   end
endmodule

// File: rtl/fx2_multi_ep.sv
// FX2 slave-FIFO master: drains EP2 into the command stream and feeds up to
// three IN endpoints with round-robin bursts and idle-flush packet commits.
module fx2_multi_ep
   import fx2_pkg::*;
#(
   parameter int FD_WIDTH    = 8,
   parameter int N_IN        = 3,
   parameter int TURNAROUND  = 2,
   parameter int BURST_MAX   = 64,
   parameter int FLUSH_TICKS = 4096
) (
   input  logic                fx2_clk,
   input  logic                reset_n,
   inout  wire  [FD_WIDTH-1:0] fx2_fd,
   input  logic [3:0]          fx2_flags,
   output logic [1:0]          fx2_fifoadr,
   output logic                fx2_slrd,
   output logic                fx2_slwr,
   output logic                fx2_sloe,
   output logic                fx2_pktend,
   output logic                fx2_wu2,
   fx2_multi_ep_if.master      core
);
   localparam int TW = $clog2(TURNAROUND + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int CW = (FLUSH_TICKS > 0) ? $clog2(FLUSH_TICKS + 1) : 1;

   state_t                     state, nstate;
   logic [1:0]                 ch;
   logic                       flush_q;
   logic [TW-1:0]              turn_cnt;
   logic [BW-1:0]              burst;
   logic [FD_WIDTH-1:0]        cmd_q;
   logic                       cmd_wr_q;
   logic [N_IN-1:0]            dirty;
   logic [N_IN-1:0][CW-1:0]    idle_cnt;
   logic [N_IN-1:0]            ack;
   logic [2:0]                 in_nf;
   logic                       out_ok, in_go, wr, burst_last, fd_oe;
   logic                       flush_any, arb_any, arb_take;
   logic [1:0]                 flush_idx, arb_idx;

   assign in_nf      = fx2_flags[3:FLAG_IN0];
   assign out_ok     = fx2_flags[FLAG_EP2] && !core.cmd_full;
   assign in_go      = core.in_rdy[ch] && in_nf[ch];
   assign wr         = (state == ST_IN_WR) && in_go;
   assign burst_last = (burst == BW'(BURST_MAX - 1));
   assign arb_take   = (state == ST_IDLE) && !out_ok && !flush_any && arb_any;

   assign fx2_fd      = fd_oe ? core.in_data[ch] : {FD_WIDTH{1'bz}};
   assign fx2_wu2     = 1'b1;
   assign core.cmd    = cmd_q;
   assign core.cmd_wr = cmd_wr_q;
   assign core.in_ack = ack;

   fx2_rr_arbiter #(.N(N_IN)) u_arb (
      .clk   (fx2_clk),
      .rst_n (reset_n),
      .req   (core.in_rdy & in_nf[N_IN-1:0]),
      .take  (arb_take),
      .any   (arb_any),
      .gidx  (arb_idx)
   );

   // lowest-index dirty channel whose idle counter has reached the limit
   always_comb begin
      flush_any = 1'b0;
      flush_idx = 2'd0;
      for (int k = N_IN - 1; k >= 0; k--) begin
         if (FLUSH_TICKS != 0 && dirty[k] && idle_cnt[k] == CW'(FLUSH_TICKS)) begin
            flush_any = 1'b1;
            flush_idx = 2'(k);
         end
      end
   end

   // state register
   always_ff @(posedge fx2_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= nstate;
   end

   // next state and pin strobes; all pins decode from state so reset frees the bus at once
   always_comb begin
      nstate      = state;
      fx2_slrd    = 1'b1;
      fx2_slwr    = 1'b1;
      fx2_sloe    = 1'b1;
      fx2_pktend  = 1'b1;
      fx2_fifoadr = ADR_EP2;
      fd_oe       = 1'b0;
      ack         = '0;
      case (state)
         ST_IDLE: begin
            if (out_ok)                    nstate = ST_OUT_TURN;
            else if (flush_any || arb_any) nstate = ST_IN_SEL;
         end
         ST_OUT_TURN: begin
            fx2_sloe = 1'b0;
            if (turn_cnt == TW'(TURNAROUND - 1)) nstate = ST_OUT_RD;
         end
         ST_OUT_RD: begin
            fx2_sloe = 1'b0;
            fx2_slrd = !out_ok;
            if (!out_ok) nstate = ST_IDLE;
         end
         ST_IN_SEL: begin
            fx2_fifoadr = chan_adr(ch);
            nstate      = flush_q ? ST_IN_PKTEND : ST_IN_WR;
         end
         ST_IN_WR: begin
            fx2_fifoadr = chan_adr(ch);
            fd_oe       = 1'b1;
            if (in_go) begin
               fx2_slwr = 1'b0;
               ack[ch]  = 1'b1;
               if (core.in_end[ch])         nstate = ST_IN_PKTEND;
               else if (burst_last || out_ok) nstate = ST_IDLE;
            end else begin
               nstate = ST_IDLE;
            end
         end
         ST_IN_PKTEND: begin
            fx2_fifoadr = chan_adr(ch);
            fx2_pktend  = 1'b0;
            nstate      = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // channel latch, turnaround/burst counters, command capture (one cycle after the strobe)
   always_ff @(posedge fx2_clk or negedge reset_n) begin
      if (!reset_n) begin
         ch       <= 2'd0;
         flush_q  <= 1'b0;
         turn_cnt <= '0;
         burst    <= '0;
         cmd_q    <= '0;
         cmd_wr_q <= 1'b0;
      end else begin
         if (state == ST_IDLE && !out_ok) begin
            if (flush_any) begin
               ch      <= flush_idx;
               flush_q <= 1'b1;
            end else if (arb_any) begin
               ch      <= arb_idx;
               flush_q <= 1'b0;
            end
         end
         turn_cnt <= (state == ST_OUT_TURN) ? turn_cnt + 1'b1 : '0;
         if (state == ST_IN_SEL) burst <= '0;
         else if (wr)            burst <= burst + 1'b1;
         cmd_wr_q <= (state == ST_OUT_RD) && out_ok;
         if ((state == ST_OUT_RD) && out_ok) cmd_q <= fx2_fd;
      end
   end

   // per-channel partial-packet tracking and idle counters (saturating)
   always_ff @(posedge fx2_clk or negedge reset_n) begin
      if (!reset_n) begin
         dirty    <= '0;
         idle_cnt <= '0;
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            if (wr && ch == 2'(k)) begin
               dirty[k]    <= !core.in_end[k];
               idle_cnt[k] <= '0;
            end else if (state == ST_IN_PKTEND && ch == 2'(k)) begin
               dirty[k]    <= 1'b0;
               idle_cnt[k] <= '0;
            end else if (dirty[k] && idle_cnt[k] != CW'(FLUSH_TICKS)) begin
               idle_cnt[k] <= idle_cnt[k] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fx2_multi_ep.sv
// Directed bench for fx2_multi_ep with a small FX2 FIFO model and core-side sources.
module tb_fx2_multi_ep;
   localparam int W = 8;
   localparam int N = 3;

   logic fx2_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 fx2_clk = ~fx2_clk;

   wire  [W-1:0] fd;
   logic [3:0]   flags;
   logic [1:0]   fifoadr;
   logic         slrd, slwr, sloe, pktend, wu2;

   fx2_multi_ep_if #(.FD_WIDTH(W), .N_IN(N)) bus ();

   fx2_multi_ep #(.FD_WIDTH(W), .N_IN(N), .TURNAROUND(2), .BURST_MAX(4), .FLUSH_TICKS(16)) dut (
      .fx2_clk(fx2_clk), .reset_n(reset_n), .fx2_fd(fd), .fx2_flags(flags),
      .fx2_fifoadr(fifoadr), .fx2_slrd(slrd), .fx2_slwr(slwr), .fx2_sloe(sloe),
      .fx2_pktend(pktend), .fx2_wu2(wu2), .core(bus)
   );

   // model state
   logic [W-1:0] ep2_mem [16];
   int           ep2_n, ep2_rd, rd_cnt, cmd_n, wr_n, pk_n, pk_cyc, last_wr_cyc, cyc;
   int           sloe_cyc, slrd_cyc, viol;
   int           ch_n [N];
   int           ch_idx [N];
   logic [N-1:0] end_en, in_nf;
   logic [W-1:0] cmd_log [16];
   logic [9:0]   wlog [32];
   logic [1:0]   pk_adr;
   int           n_cmp, n_err;

   assign flags = {in_nf, ep2_rd < ep2_n};
   assign fd    = (!sloe && fifoadr == 2'b00 && ep2_rd < ep2_n) ? ep2_mem[ep2_rd[3:0]] : {W{1'bz}};

   // core-side sources: channel k emits k*16+i, in_end on the last word when enabled
   always_comb begin
      bus.in_rdy  = '0;
      bus.in_end  = '0;
      bus.in_data = '0;
      for (int k = 0; k < N; k++) begin
         bus.in_rdy[k]  = ch_idx[k] < ch_n[k];
         bus.in_end[k]  = end_en[k] && (ch_idx[k] == ch_n[k] - 1);
         bus.in_data[k] = 8'(k * 16 + ch_idx[k]);
      end
   end

   // FX2 FIFO model and bus monitor
   always @(posedge fx2_clk or negedge reset_n) begin
      if (!reset_n) begin
         ep2_rd <= 0; rd_cnt <= 0; cmd_n <= 0; wr_n <= 0; pk_n <= 0; pk_cyc <= 0;
         last_wr_cyc <= 0; cyc <= 0; sloe_cyc <= -1; slrd_cyc <= -1; viol <= 0; pk_adr <= 2'b00;
         for (int k = 0; k < N; k++) ch_idx[k] <= 0;
      end else begin
         cyc <= cyc + 1;
         if (!sloe && sloe_cyc < 0) sloe_cyc <= cyc;
         if (!slrd) begin
            ep2_rd <= ep2_rd + 1;
            rd_cnt <= rd_cnt + 1;
            if (slrd_cyc < 0) slrd_cyc <= cyc;
         end
         if (bus.cmd_wr && cmd_n < 16) begin
            cmd_log[cmd_n] <= bus.cmd;
            cmd_n <= cmd_n + 1;
         end
         if (!slwr && wr_n < 32) begin
            wlog[wr_n] <= {fifoadr, fd};
            wr_n <= wr_n + 1;
            last_wr_cyc <= cyc;
         end
         if (!pktend) begin
            pk_n <= pk_n + 1;
            pk_adr <= fifoadr;
            pk_cyc <= cyc;
         end
         viol <= viol + int'(!slwr && !flags[fifoadr]) + int'(!slrd && !slwr)
                      + int'(dut.fd_oe && !sloe);
         for (int k = 0; k < N; k++) if (bus.in_ack[k]) ch_idx[k] <= ch_idx[k] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.cmd_full = 1'b0;
      in_nf = '1;
      end_en = '0;
      ep2_n = 0;
      for (int k = 0; k < N; k++) ch_n[k] = 0;
      repeat (2) @(posedge fx2_clk);
      @(negedge fx2_clk);
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge fx2_clk);
   endtask

   initial begin
      logic [9:0] e;
      int         c, base, seen;
      n_cmp = 0; n_err = 0;

      // reset state
      do_reset();
      chk("rst_adr", 32'(fifoadr), 0);
      chk("rst_strobes", 32'({slrd, slwr, sloe, pktend}), 32'hF);
      chk("rst_cmd", 32'({bus.cmd_wr, bus.cmd}), 0);
      chk("rst_ack", 32'(bus.in_ack), 0);
      chk("wu2", 32'(wu2), 1);

      // command read: 5 words, 2-cycle turnaround
      for (int i = 0; i < 16; i++) ep2_mem[i] = 8'(8'hA0 + i);
      ep2_n = 5;
      idle(20);
      chk("rd_count", 32'(rd_cnt), 5);
      chk("cmd_count", 32'(cmd_n), 5);
      for (int i = 0; i < 5; i++) chk("cmd_word", 32'(cmd_log[i]), 32'(8'hA0 + i));
      chk("turnaround", 32'(slrd_cyc - sloe_cyc), 2);

      // backpressure at the third word
      do_reset();
      for (int i = 0; i < 16; i++) ep2_mem[i] = 8'(8'hB0 + i);
      ep2_n = 5;
      for (int i = 0; i < 50 && rd_cnt < 3; i++) begin @(posedge fx2_clk); #1; end
      bus.cmd_full = 1'b1;
      idle(10);
      chk("bp_cmd_count", 32'(cmd_n), 3);
      chk("bp_ep2_left", 32'(ep2_n - ep2_rd), 2);
      bus.cmd_full = 1'b0;
      idle(20);
      chk("bp_resume_count", 32'(cmd_n), 5);
      chk("bp_word3", 32'(cmd_log[3]), 32'h B3);
      chk("bp_word4", 32'(cmd_log[4]), 32'h B4);

      // round robin, burst cap 4: order 0,1,2,0
      do_reset();
      ch_n[0] = 8; ch_n[1] = 4; ch_n[2] = 4;
      idle(60);
      chk("rr_count", 32'(wr_n), 16);
      for (int g = 0; g < 4; g++) begin
         c    = (g == 3) ? 0 : g;
         base = (g == 3) ? 4 : 0;
         for (int i = 0; i < 4; i++) begin
            e = {2'(c + 1), 8'(c * 16 + base + i)};
            chk("rr_word", 32'(wlog[g * 4 + i]), 32'(e));
         end
      end

      // packet end on ch1's third word; no later flush
      do_reset();
      ch_n[1] = 3; end_en[1] = 1'b1;
      idle(50);
      chk("pe_count", 32'(wr_n), 3);
      chk("pe_last", 32'(wlog[2]), 32'({2'b10, 8'h12}));
      chk("pe_pulses", 32'(pk_n), 1);
      chk("pe_adr", 32'(pk_adr), 32'(2'b10));

      // idle flush of a 2-word partial packet on ch0
      do_reset();
      ch_n[0] = 2;
      idle(40);
      chk("fl_count", 32'(wr_n), 2);
      chk("fl_pulses", 32'(pk_n), 1);
      chk("fl_adr", 32'(pk_adr), 32'(2'b01));
      chk("fl_delay", 32'(pk_cyc - last_wr_cyc), 19);

      // not-full flag drops mid-burst, then returns
      do_reset();
      ch_n[0] = 6;
      for (int i = 0; i < 50 && wr_n < 2; i++) begin @(posedge fx2_clk); #1; end
      in_nf[0] = 1'b0;
      idle(5);
      chk("ff_hold", 32'(wr_n), 2);
      in_nf[0] = 1'b1;
      idle(30);
      chk("ff_count", 32'(wr_n), 6);
      for (int i = 0; i < 6; i++) chk("ff_word", 32'(wlog[i]), 32'({2'b01, 8'(i)}));
      chk("bus_rules", 32'(viol), 0);

      // reset mid-burst releases the bus in the same cycle
      do_reset();
      ch_n[0] = 20;
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         @(posedge fx2_clk); #1;
         if (!slwr && wr_n >= 1) seen = 1;
      end
      chk("mid_burst_seen", 32'(seen), 1);
      reset_n = 1'b0;
      #1;
      chk("mr_strobes", 32'({slrd, slwr, sloe, pktend}), 32'hF);
      chk("mr_ack", 32'(bus.in_ack), 0);
      chk("mr_fd_oe", 32'(dut.fd_oe), 0);
      chk("mr_adr", 32'(fifoadr), 0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
